// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronise and debounce raw switch levels, emitting clean levels plus rise/fall pulses
// Ports:
//   clk        - system clock
//   reset_n    - asynchronous active-low reset
//   sw_raw     - asynchronous switch pins (WIDTH bits)
//   sw_out     - debounced registered level (WIDTH bits)
//   sw_rise    - one-cycle pulse per bit on debounced 0->1
//   sw_fall    - one-cycle pulse per bit on debounced 1->0
//   sw_changed - registered OR of sw_rise|sw_fall
module switch_debouncer #(
    parameter int              WIDTH           = 4,
    parameter int              DEBOUNCE_CYCLES = 50000,
    parameter int              CNT_W           = 16,
    parameter logic [WIDTH-1:0] RESET_VAL      = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [WIDTH-1:0]            s1_q, s2_q, out_q, out_d, rise_q, rise_d, fall_q, fall_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                        changed_q;
    always_comb begin
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        cnt_d  = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            // any sample matching the current level discards accumulated progress
            if (s2_q[i] == out_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != LAST) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else begin
                cnt_d[i]  = '0;
                out_d[i]  = s2_q[i];
                rise_d[i] = s2_q[i];
                fall_d[i] = ~s2_q[i];
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q      <= RESET_VAL;
            s2_q      <= RESET_VAL;
            out_q     <= RESET_VAL;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s1_q      <= sw_raw;
            s2_q      <= s1_q;
            out_q     <= out_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= |(rise_d | fall_d);
            cnt_q     <= cnt_d;
        end
    end
    assign sw_out     = out_q;
    assign sw_rise    = rise_q;
    assign sw_fall    = fall_q;
    assign sw_changed = changed_q;
endmodule
